// File: rtl/div_shift_16b_if.sv
// Request/response bundle shared by the divider and its issuing stage.
// Uses the same valid/ready/out_valid/flush handshake as the multiplier.
interface div_shift_16b_if #(
    parameter int WIDTH = 16
);
    logic             div_valid;
    logic             flush;
    logic             divw;
    logic             div_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             div_ready;
    logic             out_valid;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output div_valid, flush, divw, div_signed, dividend, divisor,
        input  div_ready, out_valid, quotient, remainder
    );

    modport slave (
        input  div_valid, flush, divw, div_signed, dividend, divisor,
        output div_ready, out_valid, quotient, remainder
    );
endinterface

// File: rtl/div_shift_16b.sv
// Iterative radix-2 restoring divider, signed/unsigned with half-width "w" mode.
// RISC-V divide-by-zero and overflow results complete one edge after accept.
module div_shift_16b #(
    parameter int WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    div_shift_16b_if.slave  bus
);
    localparam int HALF = WIDTH / 2;
    localparam int CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] remAcc_q;
    logic [WIDTH-1:0] quoAcc_q;
    logic [WIDTH-1:0] divisor_q;
    logic             negQuo_q;
    logic             negRem_q;
    logic             halfMode_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             outValid_q;

    logic [WIDTH-1:0] effA;
    logic [WIDTH-1:0] effB;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic [WIDTH-1:0] mostNeg;
    logic             divZero;
    logic             overflow;

    logic [WIDTH:0]   remShift;
    logic             trialOk;
    logic [WIDTH-1:0] remAcc_d;
    logic [WIDTH-1:0] quoAcc_d;
    logic [WIDTH-1:0] quoFinal;
    logic [WIDTH-1:0] remFinal;

    function automatic logic [WIDTH-1:0] sextHalf(input logic half, input logic [WIDTH-1:0] v);
        return half ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
    endfunction

    // Effective operands: in w mode the low half is sign- or zero-extended first.
    assign effA = bus.divw ? {{HALF{bus.div_signed & bus.dividend[HALF-1]}}, bus.dividend[HALF-1:0]}
                           : bus.dividend;
    assign effB = bus.divw ? {{HALF{bus.div_signed & bus.divisor[HALF-1]}}, bus.divisor[HALF-1:0]}
                           : bus.divisor;
    assign absA = (bus.div_signed & effA[WIDTH-1]) ? -effA : effA;
    assign absB = (bus.div_signed & effB[WIDTH-1]) ? -effB : effB;

    assign mostNeg  = bus.divw ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(WIDTH-1){1'b0}}};
    assign divZero  = (effB == '0);
    assign overflow = bus.div_signed & (effA == mostNeg) & (&effB);

    // A set top bit of the shifted remainder guarantees the trial succeeds,
    // and the true difference then still fits in WIDTH bits.
    assign remShift = {remAcc_q, quoAcc_q[WIDTH-1]};
    assign trialOk  = remShift[WIDTH] | (remShift[WIDTH-1:0] >= divisor_q);
    assign remAcc_d = trialOk ? (remShift[WIDTH-1:0] - divisor_q) : remShift[WIDTH-1:0];
    assign quoAcc_d = {quoAcc_q[WIDTH-2:0], trialOk};

    assign quoFinal = sextHalf(halfMode_q, negQuo_q ? -quoAcc_d : quoAcc_d);
    assign remFinal = sextHalf(halfMode_q, negRem_q ? -remAcc_d : remAcc_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            remAcc_q    <= '0;
            quoAcc_q    <= '0;
            divisor_q   <= '0;
            negQuo_q    <= 1'b0;
            negRem_q    <= 1'b0;
            halfMode_q  <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            outValid_q  <= 1'b0;
        end else begin
            outValid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.div_valid && !bus.flush) begin
                        halfMode_q <= bus.divw;
                        negQuo_q   <= bus.div_signed & (effA[WIDTH-1] ^ effB[WIDTH-1]);
                        negRem_q   <= bus.div_signed & effA[WIDTH-1];
                        cnt_q      <= '0;
                        if (divZero || overflow) begin
                            quotient_q  <= divZero ? '1 : effA;
                            remainder_q <= divZero ? sextHalf(bus.divw, effA) : '0;
                            outValid_q  <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            remAcc_q  <= '0;
                            quoAcc_q  <= absA;
                            divisor_q <= absB;
                            state_q   <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (bus.flush) begin
                        state_q <= IDLE;
                    end else begin
                        remAcc_q <= remAcc_d;
                        quoAcc_q <= quoAcc_d;
                        cnt_q    <= cnt_q + 1'b1;
                        if (cnt_q == LAST_ITER) begin
                            quotient_q  <= quoFinal;
                            remainder_q <= remFinal;
                            outValid_q  <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // A flush during the DONE cycle must hide that cycle's result pulse.
    assign bus.out_valid = outValid_q & ~bus.flush;
    assign bus.div_ready = (state_q == IDLE);
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
endmodule
